rvfi_seq_ctrl: RTL and testbench

Synthesizable in-order retirement sequencer for trace/RVFI records. It accepts up to 2 issue-side records per cycle from the issuer. Records that need execution stay pending until the committer reports matching ex-pipeline commits. Records are then released strictly in program order, one per cycle, over a valid/ready port into the tracer/RVFI sink. It sits between issuer, committer and the trace sink, replacing the behavioural queue with checkable hardware.

---
 rtl/rvfi_seq_pkg.sv | 37 +++
 rtl/rvfi_seq_find.sv | 41 ++++
 rtl/rvfi_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rvfi_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI retirement sequencer.
//   - entry_meta_t : per-entry control fields (the parameter-sized pl and data
//                    fields live in their own arrays inside rvfi_seq_ctrl)
//   - ERR_*        : bit positions inside err_o
//   - PL_*         : one-hot pipeline-select codes
//   - issue_pend() : number of commits a freshly issued record must wait for
package rvfi_seq_pkg;

  localparam int ERR_OVF    = 0;  // push while not ready
  localparam int ERR_PL     = 1;  // commit pipeline differs from issued pipeline
  localparam int ERR_ORPHAN = 2;  // commit with nothing pending
  localparam int ERR_AMO    = 3;  // both commit slots hit one AMO in one cycle

  localparam logic [4:0] PL_ALU0 = 5'b00010;
  localparam logic [4:0] PL_ALU1 = 5'b00100;
  localparam logic [4:0] PL_LS   = 5'b01000;
  localparam logic [4:0] PL_MULT = 5'b10000;

  typedef struct packed {
    logic       valid;
    logic       is_ex;
    logic       is_amo;
    logic [1:0] pend;
  } entry_meta_t;

  // AMOs wait for two commits, other EX records for one, the rest for none.
  function automatic logic [1:0] issue_pend(input logic is_ex, input logic is_amo);
    if (is_amo) begin
      return 2'd2;
    end
    if (is_ex) begin
      return 2'd1;
    end
    return 2'd0;
  endfunction

endpackage

// File: rtl/rvfi_seq_find.sv
// Circular search helper: starting at 'start', returns the first two set
// positions of 'mask' (in circular order) and whether each was found.
//   start  : search origin
//   mask   : one bit per queue entry
//   idx0/1 : first / second hit
//   found0/1 : hit valid flags
module rvfi_seq_find #(
  parameter int Depth = 8,
  parameter int AW    = 3
) (
  input  logic [AW-1:0]    start,
  input  logic [Depth-1:0] mask,
  output logic [AW-1:0]    idx0,
  output logic [AW-1:0]    idx1,
  output logic             found0,
  output logic             found1
);

  logic [AW-1:0] pos;

  always_comb begin
    idx0   = '0;
    idx1   = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    pos    = '0;
    for (int k = 0; k < Depth; k++) begin
      pos = start + AW'(k);
      if (mask[pos]) begin
        if (!found0) begin
          found0 = 1'b1;
          idx0   = pos;
        end else if (!found1) begin
          found1 = 1'b1;
          idx1   = pos;
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_seq_ctrl.sv
// In-order retirement sequencer for trace/RVFI records.
// Records enter from the issuer (two slots per cycle), wait for their
// ex-pipeline commits when needed, and leave one per cycle in program order.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   iss_valid_i/is_ex_i/is_amo_i/pl_i/data_i, iss_ready_o   issue side
//   cmt_valid_i/pl_i/upd_i, cmt_flush_i                     commit side
//   out_valid_o/data_o, out_ready_i                         trace sink side
//   err_o                   sticky error flags (see rvfi_seq_pkg ERR_*)
module rvfi_seq_ctrl
  import rvfi_seq_pkg::*;
#(
  parameter int Depth = 8,
  parameter int DataW = 256,
  parameter int PlW   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             iss_valid_i,
  input  logic [1:0]             iss_is_ex_i,
  input  logic [1:0]             iss_is_amo_i,
  input  logic [1:0][PlW-1:0]    iss_pl_i,
  input  logic [1:0][DataW-1:0]  iss_data_i,
  output logic                   iss_ready_o,
  input  logic [1:0]             cmt_valid_i,
  input  logic [1:0][PlW-1:0]    cmt_pl_i,
  input  logic [1:0][DataW-1:0]  cmt_upd_i,
  input  logic                   cmt_flush_i,
  output logic                   out_valid_o,
  output logic [DataW-1:0]       out_data_o,
  input  logic                   out_ready_i,
  output logic [3:0]             err_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  // ---------------- state ----------------
  entry_meta_t      meta_reg  [Depth];
  entry_meta_t      meta_next [Depth];
  logic [PlW-1:0]   pl_mem    [Depth];
  logic [PlW-1:0]   pl_next   [Depth];
  logic [DataW-1:0] data_mem  [Depth];
  logic [DataW-1:0] data_next [Depth];

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]    ex_ptr_reg, ex_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             out_valid_reg, out_valid_next;
  logic [DataW-1:0] out_data_reg, out_data_next;
  logic [3:0]       err_reg, err_next;

  // ---------------- issue side ----------------
  logic          ovf, push_en, push0, push1;
  logic [AW-1:0] wr_slot0, wr_slot1;
  logic [CW-1:0] num_push;
  logic [1:0]    pend_slot0, pend_slot1;
  logic          unused_amo1;

  assign iss_ready_o = (CW'(Depth) - count_reg) >= CW'(2);
  assign ovf         = (|iss_valid_i) & ~iss_ready_o;
  assign push_en     = iss_ready_o & ~cmt_flush_i;
  assign push0       = push_en & iss_valid_i[0];
  assign push1       = push_en & iss_valid_i[1];
  // Pushed records are packed: a lone slot-1 record lands at wr_ptr.
  assign wr_slot0    = wr_ptr_reg;
  assign wr_slot1    = wr_ptr_reg + AW'(push0);
  assign num_push    = CW'(push0) + CW'(push1);
  assign pend_slot0  = issue_pend(iss_is_ex_i[0], iss_is_amo_i[0]);
  // Slot 1 never carries an AMO; its is_amo flag is deliberately ignored.
  assign pend_slot1  = issue_pend(iss_is_ex_i[1], 1'b0);
  assign unused_amo1 = iss_is_amo_i[1];

  // ---------------- commit matching ----------------
  logic [Depth-1:0] pend_mask;
  logic [AW-1:0]    cur_idx0, cur_idx1;
  logic             cur_f0, cur_f1;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_pend
    assign pend_mask[gi] = meta_reg[gi].valid & meta_reg[gi].is_ex &
                           (meta_reg[gi].pend != 2'd0);
  end

  rvfi_seq_find #(.Depth(Depth), .AW(AW)) u_find_cur (
    .start  (ex_ptr_reg),
    .mask   (pend_mask),
    .idx0   (cur_idx0),
    .idx1   (cur_idx1),
    .found0 (cur_f0),
    .found1 (cur_f1)
  );

  logic          apply0, apply1, orphan, amo_dbl, pl_mis;
  logic [AW-1:0] tgt0, tgt1;

  always_comb begin
    apply0  = 1'b0;
    apply1  = 1'b0;
    orphan  = 1'b0;
    amo_dbl = 1'b0;
    tgt0    = cur_idx0;
    tgt1    = cur_idx1;
    if (cmt_valid_i[0]) begin
      if (cur_f0) apply0 = 1'b1;
      else        orphan = 1'b1;
      if (cmt_valid_i[1]) begin
        if (cur_f0 && meta_reg[cur_idx0].is_amo && meta_reg[cur_idx0].pend == 2'd2) begin
          // Both commits belong to one AMO: keep the first, drop the second.
          amo_dbl = 1'b1;
        end else if (cur_f1) begin
          apply1 = 1'b1;
        end else begin
          orphan = 1'b1;
        end
      end
    end else if (cmt_valid_i[1]) begin
      // A lone slot-1 commit is the oldest commit this cycle.
      tgt1 = cur_idx0;
      if (cur_f0) apply1 = 1'b1;
      else        orphan = 1'b1;
    end
  end

  assign pl_mis = (apply0 && (cmt_pl_i[0] != pl_mem[tgt0])) ||
                  (apply1 && (cmt_pl_i[1] != pl_mem[tgt1]));

  // Pending state after this cycle's commits; drives flush cut and ex_ptr.
  logic [1:0]       pend_post [Depth];
  logic [Depth-1:0] post_mask;
  logic [Depth-1:0] hit0, hit1;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_post
    assign hit0[gi]      = apply0 & (tgt0 == AW'(gi));
    assign hit1[gi]      = apply1 & (tgt1 == AW'(gi));
    assign pend_post[gi] = meta_reg[gi].pend - {1'b0, hit0[gi] | hit1[gi]};
    assign post_mask[gi] = meta_reg[gi].valid & meta_reg[gi].is_ex &
                           (pend_post[gi] != 2'd0);
  end

  logic [AW-1:0] post_idx0;
  logic          post_f0;
  logic [AW-1:0] unused_post_idx1;
  logic          unused_post_f1;

  rvfi_seq_find #(.Depth(Depth), .AW(AW)) u_find_post (
    .start  (ex_ptr_reg),
    .mask   (post_mask),
    .idx0   (post_idx0),
    .idx1   (unused_post_idx1),
    .found0 (post_f0),
    .found1 (unused_post_f1)
  );

  // ---------------- flush ----------------
  // Everything from the oldest still-pending entry up to the tail is discarded.
  logic          do_cut;
  logic [AW-1:0] cut_off;
  logic [CW-1:0] flushed;

  assign do_cut  = cmt_flush_i & post_f0;
  assign cut_off = post_idx0 - rd_ptr_reg;
  assign flushed = do_cut ? (count_reg - {1'b0, cut_off}) : '0;

  // ---------------- retire ----------------
  logic          pop;
  logic [AW-1:0] head_sel;

  assign pop      = out_valid_reg & out_ready_i;
  assign head_sel = rd_ptr_reg + AW'(pop);

  // ---------------- per-entry next state ----------------
  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    entry_meta_t      nxt;
    logic [DataW-1:0] dnxt;
    logic [PlW-1:0]   pnxt;
    logic [AW-1:0]    off;
    logic             kill;

    assign off  = AW'(gi) - post_idx0;
    assign kill = do_cut & ({1'b0, off} < flushed);

    always_comb begin
      nxt      = meta_reg[gi];
      nxt.pend = pend_post[gi];
      dnxt     = data_mem[gi];
      pnxt     = pl_mem[gi];
      if (hit0[gi]) dnxt = dnxt | cmt_upd_i[0];
      if (hit1[gi]) dnxt = dnxt | cmt_upd_i[1];
      if (pop && rd_ptr_reg == AW'(gi)) nxt.valid = 1'b0;
      if (kill) nxt = '0;
      if (push0 && wr_slot0 == AW'(gi)) begin
        nxt.valid  = 1'b1;
        nxt.is_ex  = iss_is_ex_i[0] | iss_is_amo_i[0];
        nxt.is_amo = iss_is_amo_i[0];
        nxt.pend   = pend_slot0;
        dnxt       = iss_data_i[0];
        pnxt       = iss_pl_i[0];
      end else if (push1 && wr_slot1 == AW'(gi)) begin
        nxt.valid  = 1'b1;
        nxt.is_ex  = iss_is_ex_i[1];
        nxt.is_amo = 1'b0;
        nxt.pend   = pend_slot1;
        dnxt       = iss_data_i[1];
        pnxt       = iss_pl_i[1];
      end
    end

    assign meta_next[gi] = nxt;
    assign data_next[gi] = dnxt;
    assign pl_next[gi]   = pnxt;
  end

  // ---------------- pointers, counters, outputs ----------------
  logic [3:0] err_set;

  always_comb begin
    err_set             = '0;
    err_set[ERR_OVF]    = ovf;
    err_set[ERR_PL]     = pl_mis;
    err_set[ERR_ORPHAN] = orphan;
    err_set[ERR_AMO]    = amo_dbl;
    err_next            = err_reg | err_set;

    rd_ptr_next = rd_ptr_reg + AW'(pop);
    wr_ptr_next = do_cut ? post_idx0 : (wr_ptr_reg + AW'(num_push));
    count_next  = count_reg + num_push - CW'(pop) - flushed;

    // ex_ptr tracks the oldest pending entry, or the tail when none pend.
    if (post_f0) begin
      ex_ptr_next = post_idx0;
    end else if (push0 && pend_slot0 != 2'd0) begin
      ex_ptr_next = wr_slot0;
    end else if (push1 && pend_slot1 != 2'd0) begin
      ex_ptr_next = wr_slot1;
    end else begin
      ex_ptr_next = wr_ptr_next;
    end

    // Presented from registered state, so a record resolved at one edge
    // appears after the next one; while stalled head_sel does not move.
    out_valid_next = meta_reg[head_sel].valid & (meta_reg[head_sel].pend == 2'd0);
    out_data_next  = out_valid_next ? data_mem[head_sel] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ex_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= '0;
      for (int i = 0; i < Depth; i++) begin
        meta_reg[i] <= '0;
      end
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      ex_ptr_reg    <= ex_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      err_reg       <= err_next;
      for (int i = 0; i < Depth; i++) begin
        meta_reg[i] <= meta_next[i];
      end
    end
  end

  // Payload storage needs no reset: it is only read through valid entries.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      data_mem[i] <= data_next[i];
      pl_mem[i]   <= pl_next[i];
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_rvfi_seq_ctrl.sv
// Self-checking bench for rvfi_seq_ctrl: a scoreboard queue holds the
// records expected at the sink, in program order, with commit updates merged.
module tb_rvfi_seq_ctrl;

  localparam int DW = 256;
  localparam int PW = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          iss_valid, iss_is_ex, iss_is_amo;
  logic [1:0][PW-1:0]  iss_pl;
  logic [1:0][DW-1:0]  iss_data;
  logic                iss_ready;
  logic [1:0]          cmt_valid;
  logic [1:0][PW-1:0]  cmt_pl;
  logic [1:0][DW-1:0]  cmt_upd;
  logic                cmt_flush;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_ready;
  logic [3:0]          err;

  always #5 clk = ~clk;

  rvfi_seq_ctrl #(.Depth(8), .DataW(DW), .PlW(PW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .iss_valid_i  (iss_valid),
    .iss_is_ex_i  (iss_is_ex),
    .iss_is_amo_i (iss_is_amo),
    .iss_pl_i     (iss_pl),
    .iss_data_i   (iss_data),
    .iss_ready_o  (iss_ready),
    .cmt_valid_i  (cmt_valid),
    .cmt_pl_i     (cmt_pl),
    .cmt_upd_i    (cmt_upd),
    .cmt_flush_i  (cmt_flush),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
    .err_o        (err)
  );

  int            checks   = 0;
  int            failures = 0;
  int            n_out    = 0;
  int            base;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_rec;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sink monitor: every accepted record is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      $display("retire #%0d data=%0h", n_out, out_data);
      if (exp_q.size() == 0) begin
        check("unexpected_retire", {255'd0, out_valid}, '0);
      end else begin
        exp_rec = exp_q.pop_front();
        check("retire_data", out_data, exp_rec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    iss_valid  = '0; iss_is_ex = '0; iss_is_amo = '0; iss_pl = '0; iss_data = '0;
    cmt_valid  = '0; cmt_pl = '0; cmt_upd = '0; cmt_flush = 1'b0;
  endtask

  task automatic do_issue(input logic [1:0] v, input logic [1:0] ex, input logic [1:0] amo,
                          input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    iss_valid = v; iss_is_ex = ex; iss_is_amo = amo;
    iss_pl[0] = p0; iss_pl[1] = p1; iss_data[0] = d0; iss_data[1] = d1;
    step();
    clear_in();
  endtask

  task automatic do_commit(input logic [1:0] v, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                           input logic [DW-1:0] u0, input logic [DW-1:0] u1, input logic fl);
    cmt_valid = v; cmt_pl[0] = p0; cmt_pl[1] = p1; cmt_upd[0] = u0; cmt_upd[1] = u1;
    cmt_flush = fl;
    step();
    clear_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check(tag, DW'(exp_q.size()), '0);
  endtask

  function automatic logic [DW-1:0] dval(input int k);
    return DW'(32'h1000 + k) | (DW'(1) << 200);
  endfunction

  function automatic logic [DW-1:0] uval(input int k);
    return DW'(1) << (64 + k);
  endfunction

  initial begin
    clear_in();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {255'd0, out_valid}, '0);
    check("rst_out_data", out_data, '0);
    check("rst_iss_ready", {255'd0, iss_ready}, 256'd1);
    check("rst_err", {252'd0, err}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- two non-EX records in one cycle ----
    out_ready = 1'b1;
    base = n_out;
    exp_q.push_back(256'hA1);
    exp_q.push_back(256'hB2);
    do_issue(2'b11, 2'b00, 2'b00, '0, '0, 256'hA1, 256'hB2);
    check("ab_not_early", {255'd0, out_valid}, '0);
    step();
    check("ab_a_valid", {255'd0, out_valid}, 256'd1);
    check("ab_a_data", out_data, 256'hA1);
    step();
    check("ab_b_data", out_data, 256'hB2);
    step();
    check("ab_idle", {255'd0, out_valid}, '0);
    check("ab_count", DW'(n_out - base), 256'd2);
    check("ab_err", {252'd0, err}, '0);

    // ---- EX record waits for its commit, younger non-EX waits behind it ----
    base = n_out;
    exp_q.push_back(256'hE0 | uval(1));
    exp_q.push_back(256'hD0);
    do_issue(2'b11, 2'b01, 2'b00, 5'b00010, '0, 256'hE0, 256'hD0);
    for (int i = 0; i < 3; i++) begin
      check("ex_hold", {255'd0, out_valid}, '0);
      step();
    end
    do_commit(2'b01, 5'b00010, '0, uval(1), '0, 1'b0);
    check("ex_latency", {255'd0, out_valid}, '0);
    step();
    check("ex_out_data", out_data, 256'hE0 | uval(1));
    step();
    check("ex_next_data", out_data, 256'hD0);
    drain("ex_drain");
    check("ex_count", DW'(n_out - base), 256'd2);
    check("ex_err", {252'd0, err}, '0);

    // ---- AMO: two single commits, then a dual commit on one AMO ----
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(256'hAA | uval(2) | uval(3));
    do_issue(2'b01, 2'b01, 2'b01, 5'b01000, '0, 256'hAA, '0);
    do_commit(2'b01, 5'b01000, '0, uval(2), '0, 1'b0);
    check("amo_first", {255'd0, out_valid}, '0);
    do_commit(2'b01, 5'b01000, '0, uval(3), '0, 1'b0);
    check("amo_second", {255'd0, out_valid}, '0);
    step();
    check("amo_out", out_data, 256'hAA | uval(2) | uval(3));
    drain("amo_drain");
    exp_q.push_back(256'hAB | uval(4) | uval(6));
    do_issue(2'b01, 2'b01, 2'b01, 5'b01000, '0, 256'hAB, '0);
    do_commit(2'b11, 5'b01000, 5'b01000, uval(4), uval(5), 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("amo_dbl_pending", {255'd0, out_valid}, '0);
      step();
    end
    check("amo_dbl_err", {252'd0, err}, 256'h8);
    do_commit(2'b01, 5'b01000, '0, uval(6), '0, 1'b0);
    drain("amo_dbl_drain");

    // ---- fill to full depth, overflow, then drain with paired commits ----
    do_reset();
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(dval(2*i) | uval(2*i));
      exp_q.push_back(dval(2*i+1) | uval(2*i+1));
      do_issue(2'b11, 2'b11, 2'b00, 5'b00100, 5'b00100, dval(2*i), dval(2*i+1));
      if (i == 2) check("fill_ready_6", {255'd0, iss_ready}, 256'd1);
    end
    check("fill_ready_8", {255'd0, iss_ready}, '0);
    check("fill_err_none", {252'd0, err}, '0);
    do_issue(2'b11, 2'b00, 2'b00, '0, '0, 256'hBAD0, 256'hBAD1);
    check("fill_ovf_err", {252'd0, err}, 256'h1);
    for (int j = 0; j < 4; j++) begin
      do_commit(2'b11, 5'b00100, 5'b00100, uval(2*j), uval(2*j+1), 1'b0);
    end
    drain("fill_drain");
    repeat (4) step();
    check("fill_count", DW'(n_out - base), 256'd8);
    check("fill_ready_after", {255'd0, iss_ready}, 256'd1);

    // ---- flush: R0 resolved, E1 committed in the flush cycle, E2 dropped ----
    do_reset();
    out_ready = 1'b0;
    base = n_out;
    exp_q.push_back(256'hC0);
    exp_q.push_back(256'hC1 | uval(10));
    do_issue(2'b11, 2'b10, 2'b00, '0, 5'b00010, 256'hC0, 256'hC1);
    do_issue(2'b01, 2'b01, 2'b00, 5'b00010, '0, 256'hC2, '0);
    check("fl_head_valid", {255'd0, out_valid}, 256'd1);
    check("fl_head_data", out_data, 256'hC0);
    iss_valid = 2'b01; iss_data[0] = 256'hDEAD;
    do_commit(2'b01, 5'b00010, '0, uval(10), '0, 1'b1);
    check("fl_hold_data", out_data, 256'hC0);
    step();
    check("fl_hold_data2", out_data, 256'hC0);
    out_ready = 1'b1;
    drain("fl_drain");
    exp_q.push_back(256'hC3);
    do_issue(2'b01, 2'b00, 2'b00, '0, '0, 256'hC3, '0);
    drain("fl_after_drain");
    repeat (3) step();
    check("fl_count", DW'(n_out - base), 256'd3);
    check("fl_err", {252'd0, err}, '0);

    // ---- orphan commit, then pipeline mismatch ----
    do_reset();
    do_commit(2'b01, 5'b00010, '0, uval(1), '0, 1'b0);
    check("orphan_err", {252'd0, err}, 256'h4);
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(256'hF0 | uval(20));
    do_issue(2'b01, 2'b01, 2'b00, 5'b00100, '0, 256'hF0, '0);
    do_commit(2'b01, 5'b10000, '0, uval(20), '0, 1'b0);
    drain("plmis_drain");
    check("plmis_err", {252'd0, err}, 256'h2);

    // ---- reset while a record is being presented ----
    do_reset();
    out_ready = 1'b0;
    base = n_out;
    do_issue(2'b01, 2'b00, 2'b00, '0, '0, 256'h77, '0);
    step();
    check("mid_valid", {255'd0, out_valid}, 256'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {255'd0, out_valid}, '0);
    check("mid_rst_data", out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("mid_nothing_out", DW'(n_out - base), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
